// File: rtl/coef_ctx_tracker.sv
// coef_ctx_tracker: walks one 4x4 coefficient group in reverse scan order and
// tracks the HEVC greater1/greater2 coding state, emitting c1Idx/c2Idx,
// ctx_set and greater1_ctx for every nonzero coefficient.
// Optional build macro: COEF_CTX_NZ_CNT_EN (adds the nz_count output).
module coef_ctx_tracker #(
  parameter int unsigned LEVEL_W = 16,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned C1_MAX  = 8,
  parameter int unsigned C2_MAX  = 1,
  parameter int unsigned CG_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cg_start,
  input  logic               tu_first,
  input  logic               subset_zero,
  input  logic               is_luma,
  input  logic               coef_valid,
  input  logic [LEVEL_W-1:0] coef_abs_level,
  input  logic               coef_last,
  output logic               coef_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   c1Idx,
  output logic [IDX_W-1:0]   c2Idx,
  output logic [2:0]         ctx_set,
  output logic [1:0]         greater1_ctx,
  output logic               cg_done,
  output logic               cg_err
`ifdef COEF_CTX_NZ_CNT_EN
  ,
  output logic [4:0]         nz_count
`endif
);

  localparam int unsigned CNT_W = $clog2(CG_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Working coding state; the c1Idx/c2Idx/greater1_ctx ports carry the
  // pre-update snapshot of these taken on each nonzero transfer.
  logic [IDX_W-1:0] c1_q, c2_q;
  logic [1:0]       g1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prev_q;
  logic             err_q;

  logic xfer, level_nz, level_gt1, last_slot, c1_room, c2_room;

  assign xfer      = coef_valid & coef_ready;
  assign level_nz  = (coef_abs_level != '0);
  assign level_gt1 = (coef_abs_level > LEVEL_W'(1));
  assign last_slot = (cnt_q == CNT_W'(CG_SIZE - 1));
  assign c1_room   = (c1_q < IDX_W'(C1_MAX));
  assign c2_room   = (c2_q < IDX_W'(C2_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake
  always_comb begin
    state_d    = state_q;
    coef_ready = 1'b0;
    case (state_q)
      S_IDLE: if (cg_start) state_d = S_RUN;
      S_RUN: begin
        coef_ready = 1'b1;
        if (xfer && (coef_last || last_slot)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coding state, output snapshot and CG-end pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1_q         <= '0;
      c2_q         <= '0;
      g1_q         <= 2'd1;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      err_q        <= 1'b0;
      out_valid    <= 1'b0;
      c1Idx        <= '0;
      c2Idx        <= '0;
      ctx_set      <= '0;
      greater1_ctx <= 2'd1;
      cg_done      <= 1'b0;
      cg_err       <= 1'b0;
`ifdef COEF_CTX_NZ_CNT_EN
      nz_count     <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      cg_done   <= 1'b0;
      cg_err    <= 1'b0;
      case (state_q)
        S_IDLE: if (cg_start) begin
          c1_q         <= '0;
          c2_q         <= '0;
          g1_q         <= 2'd1;
          cnt_q        <= '0;
          err_q        <= 1'b0;
          c1Idx        <= '0;
          c2Idx        <= '0;
          greater1_ctx <= 2'd1;
          if (tu_first) prev_q <= 1'b0;
          ctx_set      <= {1'b0, is_luma & ~subset_zero, prev_q & ~tu_first};
`ifdef COEF_CTX_NZ_CNT_EN
          nz_count     <= '0;
`endif
        end
        S_RUN: if (xfer) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_slot && !coef_last) err_q <= 1'b1;
          if (level_nz) begin
            out_valid    <= 1'b1;
            c1Idx        <= c1_q;
            c2Idx        <= c2_q;
            greater1_ctx <= g1_q;
`ifdef COEF_CTX_NZ_CNT_EN
            nz_count     <= nz_count + 5'd1;
`endif
            if (c1_room) begin
              if (level_gt1) begin
                g1_q <= 2'd0;
                if (c2_room) c2_q <= c2_q + IDX_W'(1);
              end else if (g1_q != 2'd0 && g1_q != 2'd3) begin
                g1_q <= g1_q + 2'd1;
              end
              c1_q <= c1_q + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          cg_done <= 1'b1;
          cg_err  <= err_q;
          prev_q  <= (g1_q == 2'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_ctx_tracker.sv
// Testbench for coef_ctx_tracker: table-driven CGs, randomized CGs against a
// closed-form reference model, and a mid-CG reset sequence.
module tb_coef_ctx_tracker;

  localparam int LEVEL_W = 16;
  localparam int IDX_W   = 8;
  localparam int C1_MAX  = 8;
  localparam int C2_MAX  = 1;
  localparam int CG_SIZE = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cg_start, tu_first, subset_zero, is_luma;
  logic               coef_valid, coef_last;
  logic [LEVEL_W-1:0] coef_abs_level;
  logic               coef_ready, out_valid, cg_done, cg_err;
  logic [IDX_W-1:0]   c1Idx, c2Idx;
  logic [2:0]         ctx_set;
  logic [1:0]         greater1_ctx;
`ifdef COEF_CTX_NZ_CNT_EN
  logic [4:0]         nz_count;
`endif

  coef_ctx_tracker #(
    .LEVEL_W(LEVEL_W), .IDX_W(IDX_W), .C1_MAX(C1_MAX),
    .C2_MAX(C2_MAX), .CG_SIZE(CG_SIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cg_start(cg_start), .tu_first(tu_first),
    .subset_zero(subset_zero), .is_luma(is_luma), .coef_valid(coef_valid),
    .coef_abs_level(coef_abs_level), .coef_last(coef_last),
    .coef_ready(coef_ready), .out_valid(out_valid), .c1Idx(c1Idx),
    .c2Idx(c2Idx), .ctx_set(ctx_set), .greater1_ctx(greater1_ctx),
    .cg_done(cg_done), .cg_err(cg_err)
`ifdef COEF_CTX_NZ_CNT_EN
    , .nz_count(nz_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c1;
    logic [7:0] c2;
    logic [1:0] g1;
  } tuple_t;

  typedef struct packed {
    logic        tf, sz, lu, poke;
    logic [4:0]  n;
    logic        has_last;
    logic [63:0] lv;      // nibble i = level of coefficient i
    logic [2:0]  e_ctx;
    logic        e_err;
    logic [4:0]  e_nout;
    logic [7:0]  e_c1, e_c2;
    logic [1:0]  e_g1;
  } vec_t;

  tuple_t       obs[$];
  int           done_cnt = 0;
  int           err_cnt  = 0;
  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [15:0]  lev [16];
  bit           m_prev = 1'b0;
  vec_t         tab [6];

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (out_valid) obs.push_back({c1Idx, c2Idx, greater1_ctx});
    if (cg_done) done_cnt++;
    if (cg_err) err_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Run one CG with levels lev[0..n-1]; compares against the reference model.
  task automatic run_cg(input bit tf, input bit sz, input bit lu, input bit poke,
                        input int n, input bit has_last, input int max_gap,
                        output int nout, output tuple_t last_t,
                        output int act_ctx, output int act_err);
    int base, exp_ctx, nz, g2, k;
    bit anyg, exp_err;
    tuple_t e;
    base    = obs.size();
    exp_ctx = ((lu && !sz) ? 2 : 0) + ((tf) ? 0 : int'(m_prev));
    exp_err = (n == CG_SIZE) && !has_last;
    @(posedge clk); #1;
    cg_start = 1'b1; tu_first = tf; subset_zero = sz; is_luma = lu;
    @(posedge clk); #1;
    cg_start = 1'b0;
    act_ctx = int'(ctx_set);
    check("ctx_set", act_ctx, exp_ctx);
    check("ready_run", int'(coef_ready), 1);
    check("c1_clear", int'(c1Idx), 0);
    check("g1_init", int'(greater1_ctx), 1);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        coef_valid = 1'b0; coef_abs_level = 16'($urandom); coef_last = 1'($urandom);
        @(posedge clk); #1;
      end
      coef_valid = 1'b1;
      coef_abs_level = lev[i];
      coef_last = has_last && (i == n - 1);
      if (poke && i == 5) begin
        cg_start = 1'b1; tu_first = 1'b1; is_luma = ~lu; subset_zero = ~sz;
      end
      @(posedge clk); #1;
      cg_start = 1'b0;
    end
    coef_valid = 1'b0; coef_last = 1'b0;
    check("ready_drop", int'(coef_ready), 0);
    @(negedge clk);
    check("done_early", int'(cg_done), 0);
    @(posedge clk); #1;
    // Closed-form model: the k-th nonzero coefficient sees
    // c1 = min(k, C1_MAX), c2 = min(#greater-than-1 among earlier counted, C2_MAX),
    // g1 = 0 once any counted level exceeded 1, else min(1 + c1, 3).
    nz = 0; g2 = 0; anyg = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (lev[i] != 0) begin
        k = (nz < C1_MAX) ? nz : C1_MAX;
        e.c1 = 8'(k);
        e.c2 = 8'((g2 < C2_MAX) ? g2 : C2_MAX);
        e.g1 = anyg ? 2'd0 : 2'(((1 + k) > 3) ? 3 : (1 + k));
        if (base + nz < obs.size()) begin
          check("tuple_c1", int'(obs[base+nz].c1), int'(e.c1));
          check("tuple_c2", int'(obs[base+nz].c2), int'(e.c2));
          check("tuple_g1", int'(obs[base+nz].g1), int'(e.g1));
        end
        if (nz < C1_MAX && lev[i] > 1) begin anyg = 1'b1; g2++; end
        nz++;
      end
    end
    nout = obs.size() - base;
    check("out_count", nout, nz);
    last_t = (nout > 0) ? obs[obs.size()-1] : '0;
    check("cg_done", int'(cg_done), 1);
    act_err = int'(cg_err);
    check("cg_err", act_err, int'(exp_err));
    check("ctx_hold", int'(ctx_set), exp_ctx);
`ifdef COEF_CTX_NZ_CNT_EN
    check("nz_count", int'(nz_count), nz);
`endif
    @(posedge clk); #1;
    check("done_pulse", int'(cg_done), 0);
    check("err_pulse", int'(cg_err), 0);
    m_prev = anyg;
  endtask

  initial begin
    int nout, act_ctx, act_err, d0, e0, n, r;
    bit hl;
    tuple_t lt;

    tab[0] = '{tf:1, sz:0, lu:1, poke:0, n:4,  has_last:1, lv:64'h1211,
               e_ctx:2, e_err:0, e_nout:4,  e_c1:3, e_c2:1, e_g1:0};
    tab[1] = '{tf:0, sz:1, lu:1, poke:0, n:2,  has_last:1, lv:64'h13,
               e_ctx:1, e_err:0, e_nout:2,  e_c1:1, e_c2:1, e_g1:0};
    tab[2] = '{tf:1, sz:0, lu:1, poke:0, n:1,  has_last:1, lv:64'h1,
               e_ctx:2, e_err:0, e_nout:1,  e_c1:0, e_c2:0, e_g1:1};
    tab[3] = '{tf:1, sz:0, lu:0, poke:0, n:10, has_last:1, lv:64'h11_1111_1111,
               e_ctx:0, e_err:0, e_nout:10, e_c1:8, e_c2:0, e_g1:3};
    tab[4] = '{tf:0, sz:0, lu:0, poke:0, n:4,  has_last:1, lv:64'h5030,
               e_ctx:0, e_err:0, e_nout:2,  e_c1:1, e_c2:1, e_g1:0};
    tab[5] = '{tf:0, sz:1, lu:1, poke:1, n:16, has_last:0, lv:64'h1111_1112_1111_1111,
               e_ctx:1, e_err:1, e_nout:16, e_c1:8, e_c2:0, e_g1:3};

    rst_n = 1'b0; cg_start = 1'b0; tu_first = 1'b0; subset_zero = 1'b0;
    is_luma = 1'b0; coef_valid = 1'b0; coef_last = 1'b0; coef_abs_level = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_c1", int'(c1Idx), 0);
    check("rst_c2", int'(c2Idx), 0);
    check("rst_ctx", int'(ctx_set), 0);
    check("rst_g1", int'(greater1_ctx), 1);
    check("rst_done", int'(cg_done), 0);
    check("rst_err", int'(cg_err), 0);
    check("rst_ready", int'(coef_ready), 0);

    // Coefficients offered in IDLE are not accepted
    coef_valid = 1'b1; coef_abs_level = 16'd5;
    repeat (2) @(posedge clk);
    #1 coef_valid = 1'b0;
    @(negedge clk);
    check("idle_ignored", obs.size(), 0);

    // Table-driven CGs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) lev[i] = {12'b0, tab[t].lv[4*i +: 4]};
      run_cg(tab[t].tf, tab[t].sz, tab[t].lu, tab[t].poke, int'(tab[t].n),
             tab[t].has_last, 0, nout, lt, act_ctx, act_err);
      check("tab_ctx", act_ctx, int'(tab[t].e_ctx));
      check("tab_err", act_err, int'(tab[t].e_err));
      check("tab_nout", nout, int'(tab[t].e_nout));
      check("tab_last_c1", int'(lt.c1), int'(tab[t].e_c1));
      check("tab_last_c2", int'(lt.c2), int'(tab[t].e_c2));
      check("tab_last_g1", int'(lt.g1), int'(tab[t].e_g1));
    end

    // Randomized CGs
    for (int t = 0; t < 25; t++) begin
      n  = int'($urandom_range(1, CG_SIZE));
      hl = (n < CG_SIZE) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)      lev[i] = 16'd0;
        else if (r < 7) lev[i] = 16'd1;
        else if (r < 9) lev[i] = 16'd2;
        else            lev[i] = 16'($urandom_range(3, 65535));
      end
      run_cg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), n, hl, 2,
             nout, lt, act_ctx, act_err);
    end

    // Mid-CG reset: set prev flag, abort a CG, then restart cleanly
    lev[0] = 16'd2;
    run_cg(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 0, nout, lt, act_ctx, act_err);
    @(posedge clk); #1;
    cg_start = 1'b1; tu_first = 1'b0; subset_zero = 1'b0; is_luma = 1'b1;
    @(posedge clk); #1;
    cg_start = 1'b0;
    check("pre_abort_ctx", int'(ctx_set), 3);
    coef_valid = 1'b1; coef_abs_level = 16'd2; coef_last = 1'b0;
    @(posedge clk); #1;
    coef_abs_level = 16'd1;
    @(posedge clk); #1;
    coef_valid = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_c1", int'(c1Idx), 0);
    check("abort_c2", int'(c2Idx), 0);
    check("abort_ctx", int'(ctx_set), 0);
    check("abort_g1", int'(greater1_ctx), 1);
    check("abort_ready", int'(coef_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_err", err_cnt - e0, 0);
    m_prev = 1'b0;
    lev[0] = 16'd1; lev[1] = 16'd2;
    run_cg(1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 0, nout, lt, act_ctx, act_err);
    check("restart_ctx", act_ctx, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/coef_ctx_tracker.md
Name: coef_ctx_tracker

Overview:
- Upstream stage of base_level_calc in the CABAC rate estimator.
- Walks the coefficients of one 4x4 coefficient group (CG) in reverse scan order and tracks the HEVC greater1/greater2 coding state.
- For every nonzero coefficient it emits the c1Idx/c2Idx pair that base_level_calc consumes, plus ctxSet and greater1Ctx for the context-bit-cost lookup.
- Carries the "previous CG ended with greater1Ctx==0" flag across CGs of one TU.

Parameters:
- LEVEL_W, 16, width of absolute coefficient level
- IDX_W, 8, width of c1Idx/c2Idx outputs (matches base_level_calc)
- C1_MAX, 8, maximum greater1 flags per CG; c1Idx saturates here
- C2_MAX, 1, maximum greater2 flags per CG; c2Idx saturates here
- CG_SIZE, 16, coefficients per CG

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cg_start  in  1  pulse: begin a new CG (accepted in IDLE only)
- tu_first  in  1  sampled with cg_start: first coded CG of the TU; clears the prev-c1-zero flag
- subset_zero  in  1  sampled with cg_start: this CG is subset 0 (DC CG)
- is_luma  in  1  sampled with cg_start
- coef_valid  in  1  coefficient present on coef_abs_level
- coef_abs_level  in  LEVEL_W  absolute level of the coefficient
- coef_last  in  1  marks the final coefficient of the CG
- coef_ready  out  1  high in RUN only; transfer = coef_valid & coef_ready
- out_valid  out  1  registered; one pulse per accepted nonzero coefficient
- c1Idx  out  IDX_W  greater1 flags already coded in this CG
- c2Idx  out  IDX_W  greater2 flags already coded in this CG
- ctx_set  out  3  context set (0..3) for the CG
- greater1_ctx  out  2  greater1 context (0..3) applying to this coefficient
- cg_done  out  1  one-cycle pulse after the CG ends
- cg_err  out  1  pulses with cg_done when CG_SIZE coefficients were accepted without coef_last

Behaviour:
- Clock clk; reset rst_n is synchronous and active-low.
- Reset: state IDLE. All outputs are 0 except greater1_ctx=1. The prev-c1-zero flag and the coefficient counter are cleared.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE, on cg_start:
  - Clear c1Idx and c2Idx; set greater1_ctx=1; clear the coefficient counter.
  - If tu_first, clear the prev flag.
  - ctx_set = ((is_luma & ~subset_zero) ? 2 : 0) + prev flag (flag already cleared when tu_first).
  - Go to RUN.
  - coef_valid in IDLE is ignored.
- RUN, per transfer:
  - Increment the coefficient counter.
  - If level==0: no out_valid, no state update.
  - If level!=0: next cycle out_valid=1 with the pre-update c1Idx, c2Idx and greater1_ctx. Latency 1 cycle.
  - Update, only when pre-update c1Idx < C1_MAX:
    - If level>1: greater1_ctx=0, and c2Idx++ when c2Idx < C2_MAX.
    - Else, if 0 < greater1_ctx < 3: greater1_ctx++.
    - Then c1Idx++.
  - When pre-update c1Idx == C1_MAX, c1Idx and c2Idx hold and greater1_ctx is frozen.
- RUN exit:
  - A transfer with coef_last, or the CG_SIZE-th transfer, moves the FSM to DONE.
  - The CG_SIZE-th transfer without coef_last also sets cg_err.
- DONE (one cycle):
  - cg_done=1; prev flag <= (greater1_ctx==0).
  - Next state IDLE. cg_start is accepted again the following cycle.
- cg_start in RUN or DONE is ignored.
- c1Idx, c2Idx, ctx_set and greater1_ctx hold their last values between out_valid pulses and through IDLE until the next cg_start.
- Width rules: c1Idx and c2Idx are zero-extended to IDX_W. Levels are unsigned, and only the comparisons ==0 and >1 are used.
- rst_n low mid-CG aborts immediately: back to reset values, with no cg_done and no cg_err pulse.

Optional Feature:
- Macro: COEF_CTX_NZ_CNT_EN.
- Defined: adds output nz_count [4:0].
  - Counts nonzero coefficients accepted in the current CG; cleared on cg_start.
  - Valid and stable while cg_done=1, and held afterwards.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Luma, tu_first=1, subset_zero=0, levels 1,1,2,1 (last on 4th) -> ctx_set=2. out_valid tuples (c1Idx,c2Idx,g1ctx) = (0,0,1), (1,0,2), (2,0,3), (3,1,0). cg_done one cycle after the last output.
- Follow-on CG, luma, tu_first=0, subset_zero=1 -> ctx_set=1 (prev flag set, greater1_ctx ended 0). A third CG with tu_first=1 -> ctx_set=2 when subset_zero=0.
- Ten level-1 coefficients -> c1Idx outputs 0..7 then 8, 8. greater1_ctx 1,2,3,3,3,3,3,3, then frozen at 3. c2Idx stays 0.
- Levels 0,3,0,5 with last, chroma -> ctx_set=0. Only two out_valid pulses: (0,0,1) and (1,1,0). c2Idx saturates at 1.
- 16 transfers, none with coef_last -> cg_done and cg_err pulse together. coef_ready drops after the 16th transfer. cg_start during RUN is ignored.
- rst_n=0 for one cycle after the 2nd coefficient -> all outputs at reset values, with no cg_done or cg_err pulse. A new cg_start then restarts cleanly with ctx_set computed from a cleared prev flag.
